// File: rtl/switch_load_ctrl.sv
// Switch-triggered loader for the 32-bit switch data register: synchronises and
// debounces the board switches, arbitrates against CPU writes and exposes status/irq.
module switch_load_ctrl #(
   parameter int               ANCHO      = 32,
   parameter logic [ANCHO-1:0] DIR_DATO   = 'h314,
   parameter logic [ANCHO-1:0] DIR_ESTADO = 'h318,
   parameter int               DEB_CICLOS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ANCHO-1:0] addr,
   input  logic             we,
   input  logic [ANCHO-1:0] wdata,
   output logic [ANCHO-1:0] rdata,
   input  logic [15:0]      sw,
   input  logic [ANCHO-1:0] reg_q,
   output logic             reg_we,
   output logic [ANCHO-1:0] reg_d,
   output logic             irq
);

   // state | meaning
   // IDLE  | no load request seen
   // DEB   | request held, waiting for the value to stay stable
   // LOAD  | driving reg_we with the latched switch value
   // HOLD  | load done, waiting for the request switch to drop
   typedef enum logic [1:0] {IDLE, DEB, LOAD, HOLD} state_t;

   localparam logic [15:0] DEB_LAST = 16'(DEB_CICLOS - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  val_q, val_d;
   logic        pending_q, pending_d;
   logic        irq_q, irq_d;
   logic [5:0]  sync1_q, sync1_d;
   logic [5:0]  sync2_q, sync2_d;

   logic        sw_req_s;
   logic [4:0]  sw_val_s;
   logic        cpu_dat_wr;
   logic        cpu_clr;
   logic        pend_set;
   logic        busy;
   logic        unused_sw;

   assign unused_sw = ^sw[14:5];

   assign sw_req_s   = sync2_q[5];
   assign sw_val_s   = sync2_q[4:0];
   assign cpu_dat_wr = we && (addr == DIR_DATO);
   assign cpu_clr    = we && (addr == DIR_ESTADO) && wdata[0];
   assign busy       = (state_q != IDLE);

   always_comb begin
      sync1_d = {sw[15], sw[4:0]};
      sync2_d = sync1_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      val_d    = val_q;
      pend_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (sw_req_s) begin
               state_d = DEB;
               cnt_d   = 16'd0;
               val_d   = sw_val_s;
            end
         end
         DEB: begin
            if (!sw_req_s) begin
               state_d = IDLE;
            end else if (sw_val_s != val_q) begin
               val_d = sw_val_s;
               cnt_d = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == DEB_LAST) state_d = LOAD;
            end
         end
         LOAD: begin
            // a CPU data write takes the register port; the switch load retries next cycle
            if (!cpu_dat_wr) begin
               state_d  = HOLD;
               pend_set = 1'b1;
            end
         end
         HOLD: begin
            if (!sw_req_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      if (pend_set)     pending_d = 1'b1;
      else if (cpu_clr) pending_d = 1'b0;
      irq_d = pending_q;
   end

   always_comb begin
      reg_we = 1'b0;
      reg_d  = '0;
      if (rst) begin
         if (cpu_dat_wr) begin
            reg_we = 1'b1;
            reg_d  = wdata;
         end else if (state_q == LOAD) begin
            reg_we = 1'b1;
            reg_d  = {{(ANCHO-5){1'b0}}, val_q};
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (addr == DIR_DATO)        rdata = reg_q;
      else if (addr == DIR_ESTADO) rdata = {{(ANCHO-3){1'b0}}, sw_req_s, busy, pending_q};
   end

   assign irq = irq_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         val_q     <= 5'd0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
         sync1_q   <= 6'd0;
         sync2_q   <= 6'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         val_q     <= val_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
      end
   end

endmodule

// File: tb/tb_switch_load_ctrl.sv
// Bench for switch_load_ctrl: directed scenarios plus random traffic, all checked
// against a run-length reference model of the debounce/load rules.
module tb_switch_load_ctrl;

   localparam int          D     = 4;
   localparam logic [31:0] A_DAT = 32'h314;
   localparam logic [31:0] A_EST = 32'h318;
   localparam logic [31:0] A_OTH = 32'h31C;

   logic        clk, rst, we, reg_we, irq;
   logic [31:0] addr, wdata, rdata, reg_q, reg_d;
   logic [15:0] sw;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: synchroniser delay line, run length of identical request samples
   logic [15:0] m_s1, m_s2;
   int          m_run;
   logic [4:0]  m_val;
   logic        m_due, m_done, m_pend, m_irq;
   logic        exp_we, exp_irq;
   logic [31:0] exp_d, exp_rdata;

   switch_load_ctrl #(.ANCHO(32), .DIR_DATO(32'h314), .DIR_ESTADO(32'h318), .DEB_CICLOS(D)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
      .sw(sw), .reg_q(reg_q), .reg_we(reg_we), .reg_d(reg_d), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_run = 0; m_val = '0;
      m_due = 0; m_done = 0; m_pend = 0; m_irq = 0;
   endtask

   task automatic drive(input logic [15:0] s, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic cpu_d, busy;
      @(negedge clk);
      sw = s; we = w; addr = a; wdata = d; reg_q = $urandom;
      cpu_d = w && (a == A_DAT);
      busy  = (m_run > 0) || m_due || m_done;
      exp_we = 1'b0; exp_d = '0;
      if (rst) begin
         exp_we = cpu_d || m_due;
         if (cpu_d)      exp_d = d;
         else if (m_due) exp_d = {27'd0, m_val};
      end
      if (a == A_DAT)      exp_rdata = reg_q;
      else if (a == A_EST) exp_rdata = {29'd0, m_s2[15], busy, m_pend};
      else                 exp_rdata = '0;
      exp_irq = m_irq;
      #1;
   endtask

   task automatic tick();
      logic cpu_d, clr;
      cpu_d = we && (addr == A_DAT);
      clr   = we && (addr == A_EST) && wdata[0];
      @(posedge clk);
      if (rst) begin
         m_irq = m_pend;
         if (m_due && !cpu_d) m_pend = 1'b1;
         else if (clr)        m_pend = 1'b0;
         if (m_due) begin
            if (!cpu_d) begin m_due = 0; m_done = 1; end
         end else if (m_done) begin
            if (!m_s2[15]) m_done = 0;
         end else if (!m_s2[15]) begin
            m_run = 0;
         end else if (m_run == 0 || m_s2[4:0] != m_val) begin
            m_val = m_s2[4:0];
            m_run = 1;
         end else begin
            m_run++;
            if (m_run == D + 1) begin m_due = 1; m_run = 0; end
         end
         m_s2 = m_s1;
         m_s1 = sw;
      end
   endtask

   task automatic test_reset();
      int pulses = 0;
      logic [31:0] val = '0;
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         drive(16'h8015, 1'b1, (i % 2) ? A_EST : A_DAT, 32'hDEAD_BEEF);
         n_cmp += 4;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL rst_hold reg_we got %b want %b", reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL rst_hold reg_d got %h want %h", reg_d, exp_d); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL rst_hold rdata got %h want %h", rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL rst_hold irq got %b want %b", irq, exp_irq); end
         tick();
      end
      #2 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(16'h8015, 1'b0, A_EST, 32'd0);
         n_cmp += 2;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL rst_pre reg_we got %b want %b", reg_we, exp_we); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL rst_pre rdata got %h want %h", rdata, exp_rdata); end
         tick();
      end
      #2 rst = 1'b0;
      model_clear();
      for (int i = 0; i < 2; i++) begin
         drive(16'h8015, 1'b0, A_EST, 32'd0);
         n_cmp += 3;
         if (reg_we !== 1'b0) begin n_err++; $display("FAIL rst_mid reg_we got %b want 0", reg_we); end
         if (rdata !== 32'd0) begin n_err++; $display("FAIL rst_mid rdata got %h want 0", rdata); end
         if (irq !== 1'b0) begin n_err++; $display("FAIL rst_mid irq got %b want 0", irq); end
         tick();
      end
      #2 rst = 1'b1;
      for (int i = 0; i < D + 12; i++) begin
         drive((i < D + 8) ? 16'h8015 : 16'h0000, 1'b0, (i % 3 == 0) ? A_DAT : A_EST, 32'd0);
         n_cmp += 4;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL rst_after reg_we got %b want %b", reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL rst_after reg_d got %h want %h", reg_d, exp_d); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL rst_after rdata got %h want %h", rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL rst_after irq got %b want %b", irq, exp_irq); end
         if (reg_we === 1'b1) begin pulses++; val = reg_d; end
         tick();
      end
      n_cmp += 2;
      if (pulses != 1) begin n_err++; $display("FAIL rst_fresh_load pulses got %0d want 1", pulses); end
      if (val !== 32'h15) begin n_err++; $display("FAIL rst_fresh_load data got %h want 15", val); end
   endtask

   task automatic test_load();
      int pulses = 0;
      int at = -1;
      logic [31:0] val = '0;
      logic [31:0] st = '0;
      for (int i = 0; i < 4; i++) begin
         drive(16'h0000, i == 0, A_EST, 32'd1);
         tick();
      end
      for (int i = 1; i <= D + 8; i++) begin
         drive(16'h8013, 1'b0, A_EST, 32'd0);
         n_cmp += 4;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL load reg_we cyc %0d got %b want %b", i, reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL load reg_d cyc %0d got %h want %h", i, reg_d, exp_d); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL load rdata cyc %0d got %h want %h", i, rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL load irq cyc %0d got %b want %b", i, irq, exp_irq); end
         if (reg_we === 1'b1) begin pulses++; at = i; val = reg_d; end
         st = rdata;
         tick();
      end
      n_cmp += 4;
      if (pulses != 1) begin n_err++; $display("FAIL load_pulses got %0d want 1", pulses); end
      if (at != D + 4) begin n_err++; $display("FAIL load_latency got %0d want %0d", at, D + 4); end
      if (val !== 32'h13) begin n_err++; $display("FAIL load_data got %h want 13", val); end
      if (st[2:0] !== 3'b111) begin n_err++; $display("FAIL load_status got %b want 111", st[2:0]); end
      for (int i = 0; i < 5; i++) begin
         drive(16'h0000, 1'b0, A_EST, 32'd0);
         n_cmp += 1;
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL release rdata got %h want %h", rdata, exp_rdata); end
         st = rdata;
         tick();
      end
      n_cmp += 1;
      if (st[1] !== 1'b0) begin n_err++; $display("FAIL release_busy got %b want 0", st[1]); end
   endtask

   task automatic test_bounce();
      int early = 0;
      int pulses = 0;
      int at = -1;
      logic [31:0] val = '0;
      for (int i = 0; i < 3; i++) begin drive(16'h0000, 1'b0, A_EST, 32'd0); tick(); end
      for (int i = 0; i < 14; i++) begin
         drive(((i / 2) % 2) ? 16'h8005 : 16'h8004, 1'b0, A_EST, 32'd0);
         n_cmp += 2;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL bounce reg_we got %b want %b", reg_we, exp_we); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL bounce rdata got %h want %h", rdata, exp_rdata); end
         if (reg_we === 1'b1) early++;
         tick();
      end
      for (int i = 0; i < D + 8; i++) begin
         drive(16'h8005, 1'b0, A_EST, 32'd0);
         n_cmp += 2;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL stable reg_we got %b want %b", reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL stable reg_d got %h want %h", reg_d, exp_d); end
         if (reg_we === 1'b1) begin pulses++; at = i; val = reg_d; end
         tick();
      end
      n_cmp += 4;
      if (early != 0) begin n_err++; $display("FAIL bounce_quiet pulses got %0d want 0", early); end
      if (pulses != 1) begin n_err++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
      if (at != D + 3) begin n_err++; $display("FAIL bounce_latency got %0d want %0d", at, D + 3); end
      if (val !== 32'h5) begin n_err++; $display("FAIL bounce_data got %h want 5", val); end
      for (int i = 0; i < 4; i++) begin drive(16'h0000, 1'b0, A_EST, 32'd0); tick(); end
   endtask

   task automatic test_collision();
      int sw_pulses = 0;
      int rises = 0;
      logic prev_p = 1'b0;
      for (int i = 0; i < 4; i++) begin drive(16'h0000, i == 0, A_EST, 32'd1); tick(); end
      for (int i = 0; i < D + 8; i++) begin
         drive(16'h8009, i == D + 3, (i == D + 3) ? A_DAT : A_EST, 32'hABCD);
         n_cmp += 4;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL coll reg_we cyc %0d got %b want %b", i, reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL coll reg_d cyc %0d got %h want %h", i, reg_d, exp_d); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL coll rdata cyc %0d got %h want %h", i, rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL coll irq cyc %0d got %b want %b", i, irq, exp_irq); end
         if (i == D + 3) begin
            n_cmp += 1;
            if (reg_d !== 32'hABCD) begin n_err++; $display("FAIL coll_cpu_wins reg_d got %h want abcd", reg_d); end
         end
         if (i == D + 4) begin
            n_cmp += 1;
            if (reg_we !== 1'b1 || reg_d !== 32'h9) begin
               n_err++; $display("FAIL coll_retry we/d got %b/%h want 1/9", reg_we, reg_d);
            end
         end
         if (reg_we === 1'b1 && !we) sw_pulses++;
         if (addr == A_EST) begin
            if (rdata[0] === 1'b1 && !prev_p) rises++;
            prev_p = rdata[0];
         end
         tick();
      end
      n_cmp += 2;
      if (sw_pulses != 1) begin n_err++; $display("FAIL coll_sw_pulses got %0d want 1", sw_pulses); end
      if (rises != 1) begin n_err++; $display("FAIL coll_pending_sets got %0d want 1", rises); end
      for (int i = 0; i < 4; i++) begin drive(16'h0000, 1'b0, A_EST, 32'd0); tick(); end
   endtask

   task automatic test_w1c();
      logic [1:0] w_data [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
      logic [31:0] st = '0;
      for (int i = 0; i < 4; i++) begin
         drive(16'h0000, i < 2, A_EST, {30'd0, w_data[i]});
         n_cmp += 2;
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL w1c rdata step %0d got %h want %h", i, rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL w1c irq step %0d got %b want %b", i, irq, exp_irq); end
         if (i == 1) begin
            n_cmp += 1;
            if (rdata[0] !== 1'b1) begin n_err++; $display("FAIL w1c_zero_no_clear pending got %b want 1", rdata[0]); end
         end
         if (i == 3) begin
            n_cmp += 2;
            if (rdata[0] !== 1'b0) begin n_err++; $display("FAIL w1c_clear pending got %b want 0", rdata[0]); end
            if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b want 0", irq); end
         end
         tick();
      end
      for (int i = 0; i < D + 6; i++) begin
         drive(16'h8011, i == D + 3, A_EST, 32'd1);
         n_cmp += 3;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL w1c_set reg_we got %b want %b", reg_we, exp_we); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL w1c_set rdata got %h want %h", rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL w1c_set irq got %b want %b", irq, exp_irq); end
         st = rdata;
         tick();
      end
      n_cmp += 1;
      if (st[0] !== 1'b1) begin n_err++; $display("FAIL w1c_set_wins pending got %b want 1", st[0]); end
      for (int i = 0; i < 4; i++) begin drive(16'h0000, 1'b0, A_EST, 32'd0); tick(); end
   endtask

   task automatic test_decode();
      drive(16'h0000, 1'b1, A_OTH, 32'hFFFF_FFFF);
      n_cmp += 3;
      if (reg_we !== 1'b0) begin n_err++; $display("FAIL decode_we got %b want 0", reg_we); end
      if (reg_d !== 32'd0) begin n_err++; $display("FAIL decode_d got %h want 0", reg_d); end
      if (rdata !== 32'd0) begin n_err++; $display("FAIL decode_rd_other got %h want 0", rdata); end
      tick();
      drive(16'h0000, 1'b0, A_OTH, 32'd0);
      n_cmp += 1;
      if (rdata !== 32'd0) begin n_err++; $display("FAIL decode_rd_other2 got %h want 0", rdata); end
      tick();
      drive(16'h0000, 1'b0, A_DAT, 32'd0);
      n_cmp += 1;
      if (rdata !== exp_rdata) begin n_err++; $display("FAIL decode_rd_data got %h want %h", rdata, exp_rdata); end
      tick();
   endtask

   task automatic test_random();
      logic [15:0] s = '0;
      logic [31:0] a, d;
      logic        w;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) s = {($urandom_range(0, 3) != 0), 10'd0, 5'($urandom_range(0, 3))};
         w = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0: a = A_DAT;
            1: a = A_EST;
            2: a = A_OTH;
            default: a = $urandom;
         endcase
         d = $urandom;
         drive(s, w, a, d);
         n_cmp += 4;
         if (reg_we !== exp_we) begin n_err++; $display("FAIL rand reg_we cyc %0d got %b want %b", i, reg_we, exp_we); end
         if (reg_d !== exp_d) begin n_err++; $display("FAIL rand reg_d cyc %0d got %h want %h", i, reg_d, exp_d); end
         if (rdata !== exp_rdata) begin n_err++; $display("FAIL rand rdata cyc %0d got %h want %h", i, rdata, exp_rdata); end
         if (irq !== exp_irq) begin n_err++; $display("FAIL rand irq cyc %0d got %b want %b", i, irq, exp_irq); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; sw = '0; we = 1'b0; addr = '0; wdata = '0; reg_q = '0;
      model_clear();
      test_reset();
      test_load();
      test_bounce();
      test_collision();
      test_w1c();
      test_decode();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
